// File: rtl/keypad_scanner.sv
// Matrix-keypad scanner: one-cold column drive, synchronised row sampling,
// frame-based single/multi key classification, debounce and a valid/ready press event.
module keypad_scanner #(
  parameter int NUM_ROWS        = 4,
  parameter int NUM_COLS        = 4,
  parameter int SCAN_CYCLES     = 100000,
  parameter int SETTLE_CYCLES   = 8,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int CODE_W          = $clog2(NUM_ROWS*NUM_COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_held,
  output logic              key_multi,
  output logic              overflow
);

  localparam int CNT_W = $clog2(SCAN_CYCLES);
  localparam int COL_W = $clog2(NUM_COLS);
  localparam int DB_W  = $clog2(DEBOUNCE_FRAMES+1);

  typedef enum logic [1:0] {S_DRIVE, S_SAMPLE, S_DWELL} scan_state_t;
  typedef enum logic [1:0] {K_NONE, K_SINGLE, K_MULTI} key_class_t;

  scan_state_t r_state, w_state_nxt;
  logic [NUM_ROWS-1:0]               r_row_meta, r_row_sync;
  logic [CNT_W-1:0]                  r_cnt, w_cnt_nxt;
  logic [COL_W-1:0]                  r_col_idx, w_col_nxt;
  logic [NUM_COLS-1:0]               r_col, w_col_drv;
  logic [NUM_COLS-1:0][NUM_ROWS-1:0] r_map;
  logic                              r_eof, w_wrap, w_sample;
  logic [1:0]                        w_nset;
  logic [CODE_W-1:0]                 w_code;
  key_class_t                        w_cls;
  key_class_t                        r_cand_cls, r_deb_cls;
  logic [CODE_W-1:0]                 r_cand_code, r_deb_code;
  logic [DB_W-1:0]                   r_stab, w_stab_nxt;
  logic                              w_same, w_accept, w_event;
  logic [CODE_W-1:0]                 r_key_code;
  logic                              r_key_valid, r_overflow;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_col_nxt   = r_col_idx;
    w_sample    = 1'b0;
    w_wrap      = 1'b0;
    case (r_state)
      S_DRIVE:  if (r_cnt == CNT_W'(SETTLE_CYCLES+1)) w_state_nxt = S_SAMPLE;
      S_SAMPLE: begin
        w_sample    = 1'b1;
        w_state_nxt = S_DWELL;
      end
      S_DWELL: begin
        if (r_cnt == CNT_W'(SCAN_CYCLES-1)) begin
          w_state_nxt = S_DRIVE;
          w_cnt_nxt   = '0;
          if (r_col_idx == COL_W'(NUM_COLS-1)) begin
            w_col_nxt = '0;
            w_wrap    = 1'b1;
          end else begin
            w_col_nxt = r_col_idx + COL_W'(1);
          end
        end
      end
      default: w_state_nxt = S_DRIVE;
    endcase
  end

  assign w_col_drv = ~(NUM_COLS'(1) << w_col_nxt);

  // Count set bits saturating at two; the code is only meaningful when exactly one is set.
  always_comb begin
    w_nset = 2'd0;
    w_code = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (r_map[c][r]) begin
          if (w_nset != 2'd2) w_nset = w_nset + 2'd1;
          w_code = CODE_W'(r*NUM_COLS + c);
        end
      end
    end
    w_cls = K_NONE;
    case (w_nset)
      2'd0:    w_cls = K_NONE;
      2'd1:    w_cls = K_SINGLE;
      default: w_cls = K_MULTI;
    endcase
  end

  assign w_same     = (w_cls == r_cand_cls) && ((w_cls != K_SINGLE) || (w_code == r_cand_code));
  assign w_stab_nxt = !w_same ? DB_W'(1) :
                      (r_stab == DB_W'(DEBOUNCE_FRAMES)) ? r_stab : r_stab + DB_W'(1);
  assign w_accept   = r_eof && (w_stab_nxt == DB_W'(DEBOUNCE_FRAMES));
  assign w_event    = w_accept && (w_cls == K_SINGLE) &&
                      !((r_deb_cls == K_SINGLE) && (r_deb_code == w_code));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_meta  <= '1;
      r_row_sync  <= '1;
      r_state     <= S_DRIVE;
      r_cnt       <= '0;
      r_col_idx   <= '0;
      r_col       <= '1;
      r_map       <= '0;
      r_eof       <= 1'b0;
      r_cand_cls  <= K_NONE;
      r_cand_code <= '0;
      r_stab      <= '0;
      r_deb_cls   <= K_NONE;
      r_deb_code  <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_row_meta <= row;
      r_row_sync <= r_row_meta;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_col_idx  <= w_col_nxt;
      r_col      <= w_col_drv;
      r_eof      <= w_wrap;
      // Column 0 of the next frame samples well after the classify cycle, so clearing here is safe.
      if (r_eof)         r_map <= '0;
      else if (w_sample) r_map[r_col_idx] <= ~r_row_sync;
      if (r_eof) begin
        r_cand_cls  <= w_cls;
        r_cand_code <= w_code;
        r_stab      <= w_stab_nxt;
        if (w_accept) begin
          r_deb_cls  <= w_cls;
          r_deb_code <= w_code;
        end
      end
      if (w_event && (!r_key_valid || key_ready)) begin
        r_key_valid <= 1'b1;
        r_key_code  <= w_code;
      end else begin
        if (w_event)   r_overflow  <= 1'b1;
        if (key_ready) r_key_valid <= 1'b0;
      end
    end
  end

  assign col       = r_col;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = (r_deb_cls == K_SINGLE);
  assign key_multi = (r_deb_cls == K_MULTI);
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad pin model, frame-level behavioural model with
// per-cycle output comparison, plus directed literal checks.
module tb_keypad_scanner;
  localparam int NR = 4, NC = 4, SCAN = 16, SETTLE = 4, DEB = 2, CW = 4;
  localparam int FRAME = NC*SCAN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0] row;
  logic [NC-1:0] col;
  logic [CW-1:0] key_code;
  logic key_valid, key_ready, key_held, key_multi, overflow;
  logic [NR*NC-1:0] keys;
  int n_chk = 0, n_pass = 0, n_acc = 0;

  keypad_scanner #(.NUM_ROWS(NR), .NUM_COLS(NC), .SCAN_CYCLES(SCAN),
                   .SETTLE_CYCLES(SETTLE), .DEBOUNCE_FRAMES(DEB)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held),
    .key_multi(key_multi), .overflow(overflow));

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = '1;
    for (int k = 0; k < NR*NC; k++)
      if (keys[k] && !col[k % NC]) row[k / NC] = 1'b0;
  end

  // Frame-level model: class 0 none, 1 single, 2 multi.
  int m_g, m_pcls, m_pcode, m_prev_cls, m_prev_code, m_stab, m_deb_cls, m_deb_code, m_code;
  logic m_pend, m_vld, m_ovf;
  int f_n, f_cls, f_code, d_stab;
  logic d_same, d_acc, d_evt;

  always_comb begin
    f_n    = $countones(keys);
    f_cls  = (f_n == 0) ? 0 : (f_n == 1) ? 1 : 2;
    f_code = 0;
    for (int k = 0; k < NR*NC; k++) if (keys[k]) f_code = k;
    d_same = (m_pcls == m_prev_cls) && (m_pcls != 1 || m_pcode == m_prev_code);
    d_stab = d_same ? ((m_stab + 1 > DEB) ? DEB : m_stab + 1) : 1;
    d_acc  = m_pend && (d_stab == DEB);
    d_evt  = d_acc && (m_pcls == 1) && !(m_deb_cls == 1 && m_deb_code == m_pcode);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_g <= 0; m_pend <= 1'b0; m_pcls <= 0; m_pcode <= 0;
      m_prev_cls <= 0; m_prev_code <= 0; m_stab <= 0;
      m_deb_cls <= 0; m_deb_code <= 0; m_vld <= 1'b0; m_code <= 0; m_ovf <= 1'b0;
    end else begin
      m_g    <= m_g + 1;
      m_pend <= ((m_g + 1) % FRAME) == 0;
      if (((m_g + 1) % FRAME) == 0) begin
        m_pcls  <= f_cls;
        m_pcode <= f_code;
      end
      if (m_pend) begin
        m_prev_cls  <= m_pcls;
        m_prev_code <= m_pcode;
        m_stab      <= d_stab;
        if (d_acc) begin
          m_deb_cls  <= m_pcls;
          m_deb_code <= m_pcode;
        end
      end
      if (d_evt && (!m_vld || key_ready)) begin
        m_vld  <= 1'b1;
        m_code <= m_pcode;
      end else begin
        if (d_evt)     m_ovf <= 1'b1;
        if (key_ready) m_vld <= 1'b0;
      end
    end
  end

  function automatic logic [NC-1:0] exp_col(input int g);
    logic [NC-1:0] v;
    v = '1;
    if (g > 0) v[(g / SCAN) % NC] = 1'b0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("col",       32'(col),       32'(exp_col(m_g)));
    chk("key_valid", 32'(key_valid), 32'(m_vld));
    chk("key_code",  32'(key_code),  32'(m_code));
    chk("key_held",  32'(key_held),  32'(m_deb_cls == 1));
    chk("key_multi", 32'(key_multi), 32'(m_deb_cls == 2));
    chk("overflow",  32'(overflow),  32'(m_ovf));
  end

  always @(posedge clk) if (!rst && key_valid && key_ready) n_acc++;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    keys = '0; key_ready = 1'b1;
    cyc(3);
    chk("rst_col", 32'(col), 32'hF);
    chk("rst_valid", 32'(key_valid), 0);
    chk("rst_code", 32'(key_code), 0);
    chk("rst_ovf", 32'(overflow), 0);
    // Key 6 = row 1, col 2, held from the start.
    keys = 16'h0040; rst = 1'b0;
    cyc(128); chk("k6_before", 32'(key_valid), 0);
    cyc(1);   chk("k6_valid", 32'(key_valid), 1);
              chk("k6_code", 32'(key_code), 6);
              chk("k6_held", 32'(key_held), 1);
    cyc(1);   chk("k6_taken", 32'(key_valid), 0);
    cyc(318); chk("k6_one_event", 32'(n_acc), 1);
    // Release: held falls after the second empty frame.
    keys = '0;
    cyc(128); chk("rel_still_held", 32'(key_held), 1);
    cyc(1);   chk("rel_held", 32'(key_held), 0);
              chk("rel_no_event", 32'(n_acc), 1);
    cyc(63);
    // Codes 1 and 5 together, then 5 alone.
    keys = 16'h0022;
    cyc(129); chk("multi", 32'(key_multi), 1);
              chk("multi_no_event", 32'(key_valid), 0);
    cyc(63);
    keys = 16'h0020;
    cyc(129); chk("k5_valid", 32'(key_valid), 1);
              chk("k5_code", 32'(key_code), 5);
              chk("k5_multi", 32'(key_multi), 0);
    cyc(63);
    keys = '0;
    cyc(128);
    // Bounce: code 3 in alternate frames only.
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h0008 : 16'h0000;
      cyc(64);
    end
    chk("bounce_held", 32'(key_held), 0);
    chk("bounce_events", 32'(n_acc), 2);
    // Overflow: code 2 pending, then code 9 dropped.
    key_ready = 1'b0;
    keys = 16'h0004; cyc(128);
    keys = '0;       cyc(128);
    keys = 16'h0200; cyc(128);
    cyc(1);   chk("ovf_valid", 32'(key_valid), 1);
              chk("ovf_code", 32'(key_code), 2);
              chk("ovf_flag", 32'(overflow), 1);
    key_ready = 1'b1;
    cyc(1);   chk("ovf_cleared", 32'(key_valid), 0);
              chk("ovf_code_kept", 32'(key_code), 2);
    key_ready = 1'b0;
    cyc(62);
    // Key 10 pending, then reset in column 3 dwell.
    keys = 16'h0400;
    cyc(129); chk("k10_valid", 32'(key_valid), 1);
              chk("k10_code", 32'(key_code), 10);
    cyc(54);  chk("dwell_col3", 32'(col), 32'h7);
    #2 rst = 1'b1;
    #1;
    chk("arst_col", 32'(col), 32'hF);
    chk("arst_valid", 32'(key_valid), 0);
    chk("arst_code", 32'(key_code), 0);
    chk("arst_ovf", 32'(overflow), 0);
    chk("arst_held", 32'(key_held), 0);
    cyc(2);
    rst = 1'b0; key_ready = 1'b1;
    cyc(1);   chk("restart_col", 32'(col), 32'hE);
    cyc(200);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
